// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// width formulas, controller state encoding and digit-correction constants.
package bin2bcd_pkg;

  // BCD output width needed to hold any n-bit binary value
  function automatic int unsigned bcd_width(input int unsigned n);
    return n + (n - 4) / 3 + 1;
  endfunction

  // Number of 4-bit digit slots covering a bw-bit BCD field
  function automatic int unsigned digit_slots(input int unsigned bw);
    return (bw + 3) / 4;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd4;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_adj3.sv
// Double-dabble digit correction cell: a digit above 4 gets +3 (4-bit wrap).
module bin2bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Correct one digit ahead of the left shift
  always_comb begin
    dout = (din > ADJ_THRESH) ? din + ADJ_ADD : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock,
// valid/ready handshakes on input and output.
// Optional macro BIN2BCD_SEQ_SKIP_EN: skip leading-zero steps on acceptance.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned BW = bcd_width(N)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [N-1:0]  BIN,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [BW-1:0] BCD,
  output logic          BUSY
);

  localparam int unsigned DIG = digit_slots(BW);
  localparam int unsigned SW  = 4 * DIG + N;
  localparam int unsigned CW  = $clog2(N + 1);

  state_t              state;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       step_next;
  logic [CW-1:0]       cnt;
  logic [DIG-1:0][3:0] adj_dig;
  logic [N-1:0]        bin_load;
  logic [CW-1:0]       cnt_load;

  // One correction cell per digit slot, including a partial top slot
  for (genvar d = 0; d < DIG; d++) begin : g_adj
    bin2bcd_adj3 u_adj3 (
      .din  (scratch[N + 4*d +: 4]),
      .dout (adj_dig[d])
    );
  end

  // Corrected digit field above the untouched binary field, then shift left
  always_comb begin
    step_next = {adj_dig, scratch[N-1:0]} << 1;
  end

`ifdef BIN2BCD_SEQ_SKIP_EN
  logic [CW-1:0] lz;
  logic          seen;

  // Leading zeros are pre-shifted out; an all-zero operand still runs one step
  always_comb begin
    lz   = '0;
    seen = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (BIN[N-1-i]) begin
        seen = 1'b1;
      end else if (!seen) begin
        lz = lz + CW'(1);
      end
    end
    bin_load = BIN << lz;
    cnt_load = (lz == CW'(N)) ? CW'(1) : CW'(N) - lz;
  end
`else
  // Fixed-latency load: operand as-is, N steps
  always_comb begin
    bin_load = BIN;
    cnt_load = CW'(N);
  end
`endif

  // Controller FSM with registered handshake outputs and result register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      BCD       <= '0;
      scratch   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            scratch  <= SW'(bin_load);
            cnt      <= cnt_load;
            state    <= CONV;
            IN_READY <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        CONV: begin
          scratch <= step_next;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b1;
            BCD       <= step_next[N +: BW];
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule
